// File: rtl/ysyx_23060192_lsu_if.sv
// =============================================================================
// ysyx_23060192_lsu_if : core request/response and AXI4-Lite data-bus bundle | Rev 1.0
// =============================================================================
`default_nettype none

interface ysyx_23060192_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // master: the LSU itself; slave: the core plus the memory system around it
  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060192_lsu.sv
// =============================================================================
// ysyx_23060192_lsu : single-outstanding load/store initiator on an AXI4-Lite data bus.
// Optional macro YSYX_23060192_LSU_MISALIGN_CHK_EN rejects misaligned requests | Rev 1.0
// =============================================================================
`default_nettype none

module ysyx_23060192_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_23060192_lsu_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]        off;
  logic [ADDR_W-1:0] addr_aligned;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data;
  logic              aw_fire, w_fire;

  assign off          = addr_q[1:0];
  assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};
  assign rd_shifted   = bus.rdata >> {off, 3'b000};

  // Size 3 is reserved and handled as a word everywhere.
  always_comb begin
    load_ext = rd_shifted;
    st_strb  = 4'b1111;
    st_data  = wdata_q;
    case (size_q)
      2'd0: begin
        load_ext = {{(DATA_W-8){~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
        st_strb  = 4'b0001 << off;
        st_data  = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        load_ext = {{(DATA_W-16){~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
        st_strb  = 4'b0011 << off;
        st_data  = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign aw_fire = (state_q == S_AW_W) && !aw_done_q && bus.awready;
  assign w_fire  = (state_q == S_AW_W) && !w_done_q && bus.wready;

`ifdef YSYX_23060192_LSU_MISALIGN_CHK_EN
  logic req_misalign;
  assign req_misalign = ((bus.req_size == 2'd1) && (bus.req_addr[1:0] == 2'd3)) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'd0));
`endif

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wen_d     = bus.req_wen;
          addr_d    = bus.req_addr;
          size_d    = bus.req_size;
          uns_d     = bus.req_unsigned;
          wdata_d   = bus.req_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b0;
          state_d   = bus.req_wen ? S_AW_W : S_AR;
`ifdef YSYX_23060192_LSU_MISALIGN_CHK_EN
          if (req_misalign) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_AR: if (bus.arready) state_d = S_R;
      S_R: begin
        if (bus.rvalid) begin
          err_d   = (bus.rresp != 2'b00);
          rdata_d = (bus.rresp != 2'b00) ? '0 : load_ext;
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (bus.bvalid) begin
          err_d   = (bus.bresp != 2'b00);
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Payloads are gated by state so idle outputs read as zero.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.arvalid    = (state_q == S_AR);
  assign bus.araddr     = (state_q == S_AR) ? addr_aligned : '0;
  assign bus.rready     = (state_q == S_R);
  assign bus.awvalid    = (state_q == S_AW_W) && !aw_done_q;
  assign bus.awaddr     = (state_q == S_AW_W) ? addr_aligned : '0;
  assign bus.wvalid     = (state_q == S_AW_W) && !w_done_q;
  assign bus.wstrb      = (state_q == S_AW_W) ? st_strb : 4'b0000;
  assign bus.wdata      = (state_q == S_AW_W) ? st_data : '0;
  assign bus.bready     = (state_q == S_B);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  assign bus.resp_err   = (state_q == S_RESP) && err_q;

  // wen_q is kept for completeness of the captured request; the path is chosen at capture.
  logic unused_ok;
  assign unused_ok = wen_q;

endmodule

`default_nettype wire

// File: doc/ysyx_23060192_lsu.md
Name: ysyx_23060192_lsu

Overview:
Load/store initiator for the NPC core. It accepts one load or store request at a time from the execute stage and issues it as a single AXI4-Lite-style transaction on the data bus. For stores it generates byte strobes and lane-aligned write data. For loads it extracts and sign- or zero-extends the returned data, then reports completion to the core with a one-cycle response pulse.

Parameters:
ADDR_W, 32, request and bus address width
DATA_W, 32, bus data width; only 32 is supported

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request; high only in IDLE
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
req_unsigned  in  1  load zero-extends when 1
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  bus error (xRESP != 0) or misalignment error
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_W  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  DATA_W  lane-aligned write data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE and all captured request fields are cleared.
- States and transitions:
  - IDLE: when req_valid is high, capture the request. A load goes to AR; a store goes to AW_W.
  - AR: arvalid = 1, araddr = {addr[31:2], 2'b00}. Move to R on arready.
  - R: rready = 1. On rvalid, register the extended data and err = (rresp != 0), then move to RESP.
  - AW_W: awvalid and wvalid are driven independently. Track aw_done and w_done. Each valid drops the cycle after its own handshake. Move to B when both are done; both may complete in the same cycle.
  - B: bready = 1. On bvalid, err = (bresp != 0), then move to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
- Valid signals are never deasserted before their handshake completes. Bus address and data stay stable while valid is high.
- Minimum latency with a zero-wait bus: capture in cycle 0 (IDLE). Load: AR at cycle 1, R at cycle 2, resp_valid at cycle 3. Store: AW_W at cycle 1, B at cycle 2, resp_valid at cycle 3.
- Store lane alignment, with off = addr[1:0]:
  - byte: wstrb = 4'b0001 << off; wdata = {4{wdata[7:0]}}
  - half: wstrb = 4'b0011 << off; wdata = {2{wdata[15:0]}}
  - word: wstrb = 4'b1111; wdata unchanged
- Load extraction: shift rdata right by 8*off, mask to the request size, then sign- or zero-extend per req_unsigned.
- Error responses still complete normally with resp_err = 1. For a load error, resp_rdata = 0.
- A new req_valid arriving while not in IDLE is ignored. req_ready is 0 outside IDLE.
- Reset asserted mid-transaction returns to IDLE on the next edge and drops all valids. No response is produced for the aborted access.
- Without the optional feature, misaligned accesses (half at off = 3 or word at off != 0) are issued as-is. Strobes that shift past bit 3 are truncated.

Optional Feature:
- Macro: YSYX_23060192_LSU_MISALIGN_CHK_EN
- Defined: an IDLE capture of a misaligned request goes directly to RESP. No bus transaction is issued; resp_err = 1 and resp_rdata = 0. Latency is 1 cycle.
- Undefined: no alignment check; behaviour is as described in Behaviour.

Test Plan:
- Load byte, signed: addr 0x8000_0003, size 0, rdata 0x80AA_BBCC, zero-wait bus -> araddr 0x8000_0000, resp_rdata 0xFFFF_FF80, resp_valid in cycle 3, resp_err 0.
- Load half, unsigned: addr 0x8000_0002, rdata 0xBEEF_1234, arready delayed 3 cycles -> resp_rdata 0x0000_BEEF; arvalid held high throughout the stall.
- Store byte: addr 0x8000_0001, wdata 0x0000_005A -> wstrb 4'b0010, wdata 0x5A5A_5A5A. Bench drives awready 2 cycles before wready -> exactly one resp_valid, after bvalid.
- Bus error: word load with rresp = 2'b10 -> resp_err 1, resp_rdata 0. Then a store with bresp = 0 -> resp_err 0.
- Reset while in R state -> next cycle state is IDLE, rready 0, req_ready 1, no resp_valid.
- With YSYX_23060192_LSU_MISALIGN_CHK_EN defined: word load at 0x8000_0002 -> no arvalid, resp_valid and resp_err 1 in cycle 1. Without the macro: araddr 0x8000_0000 is issued.
